regfile_bank8: RTL and testbench
================================

Name: regfile_bank8

Overview:
- 8-entry × WIDTH register bank that consumes the one-hot write-select vector produced by the 3-to-8 write-address decoder.
- Sits directly downstream of the decoder in the register-file datapath.
- Two synchronous read ports with same-cycle write-to-read bypass.
- Checks the decoder output for one-hot integrity and logs violations.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- ZERO_REG, 1, when 1, register 7 is hardwired to zero: writes are discarded and reads return 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request qualifier.
- wr_sel  input  8  one-hot write select from the decoder; bit i selects register i.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  3  read port A register index.
- rd_addr_b  input  3  read port B register index.
- err_clr  input  1  synchronous clear of the error flag and counter.
- rd_data_a  output  WIDTH  registered read data, port A.
- rd_data_b  output  WIDTH  registered read data, port B.
- sel_err  output  1  sticky flag: a non-one-hot wr_sel was seen with wr_en=1.
- err_count  output  8  saturating count of wr_sel violations.

Behaviour:
- Reset (reset_n=0, asynchronous, effective immediately, also mid-operation):
  - All 8 registers = 0.
  - rd_data_a = rd_data_b = 0.
  - sel_err = 0, err_count = 0.
  - State is held while reset_n=0; normal operation resumes on the first rising clk edge after reset_n returns to 1.
- Write legality, evaluated each rising edge:
  - wr_valid = wr_en AND popcount(wr_sel)==1.
  - wr_en=0: wr_sel is ignored entirely, no write, no error.
- Write:
  - On a rising edge with wr_valid=1, register i (the set bit of wr_sel) <= wr_data.
  - If ZERO_REG=1 and i=7, the write is silently discarded; this is not an error.
- Error detection:
  - Condition: wr_en=1 with popcount(wr_sel)!=1, covering both all-zero and multiple-hot selects.
  - On such an edge: no register is written, sel_err <= 1, err_count <= err_count+1, saturating at 255.
- err_clr:
  - When asserted on an edge with no violation: sel_err <= 0, err_count <= 0.
  - If err_clr and a violation occur on the same edge, the new event wins: sel_err <= 1, err_count <= 1.
- Read, 1-cycle latency:
  - On each rising edge, rd_data_a <= value of register rd_addr_a; rd_data_b likewise for rd_addr_b.
  - Reads are always enabled.
- Bypass:
  - If wr_valid=1 and the write target equals rd_addr_x on the same edge, rd_data_x <= wr_data, not the old contents.
  - This applies to both ports independently, including both ports reading the written register.
- Zero register:
  - If ZERO_REG=1 and rd_addr_x=7, rd_data_x <= 0 regardless of bypass.
  - If ZERO_REG=0, register 7 behaves like the others.
- No other state: no FSM beyond the register array, the read registers, and the error flag/counter.

Test Plan:
- Reset then read: reset_n low 2 cycles, release, rd_addr_a=3, rd_addr_b=5 -> rd_data_a=0, rd_data_b=0, sel_err=0, err_count=0.
- Write then read:
  - Stimulus: wr_en=1, wr_sel=8'b0000_0100, wr_data=32'hDEAD_BEEF; next cycle wr_en=0, rd_addr_a=2.
  - Required: rd_data_a=32'hDEAD_BEEF one edge after the address is applied.
  - Required: other registers still read 0.
- Bypass:
  - Stimulus: same edge wr_en=1, wr_sel=8'b0010_0000, wr_data=32'h1234_5678, rd_addr_a=5, rd_addr_b=5.
  - Required: both rd_data=32'h1234_5678 after that edge.
- Zero register (ZERO_REG=1):
  - Stimulus: wr_en=1, wr_sel=8'b1000_0000, wr_data=32'hFFFF_FFFF; then rd_addr_a=7.
  - Required: rd_data_a=0, sel_err=0.
- Select errors:
  - Stimulus: wr_en=1 with wr_sel=8'b0000_0011, then wr_sel=8'h00, then wr_en=0 with wr_sel=8'hFF.
  - Required: no register changes, err_count=2, sel_err=1.
  - Then err_clr=1 with a simultaneous violation -> err_count=1, sel_err=1.
  - Then err_clr=1 alone -> err_count=0, sel_err=0.
- Saturation and async reset:
  - Stimulus: 260 consecutive violations.
  - Required: err_count=255.
  - Then drop reset_n mid-cycle -> all outputs 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/regfile_bank8.sv
// regfile_bank8: 8 x WIDTH register bank driven by a one-hot write select, with two
// registered read ports, same-edge write-to-read bypass and one-hot integrity logging.
module regfile_bank8 #(
    parameter int WIDTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_sel,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [2:0]       rd_addr_a,
    input  logic [2:0]       rd_addr_b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] rd_data_a,
    output logic [WIDTH-1:0] rd_data_b,
    output logic             sel_err,
    output logic [7:0]       err_count
);
    logic [WIDTH-1:0] regs_q [8];
    logic [WIDTH-1:0] rd_data_a_q, rd_data_a_d;
    logic [WIDTH-1:0] rd_data_b_q, rd_data_b_d;
    logic             sel_err_q, sel_err_d;
    logic [7:0]       err_count_q, err_count_d;
    logic             onehot, wr_valid, sel_viol;
    logic [2:0]       wr_idx;

    // Classify the select: exactly one bit set is a legal write, anything else with wr_en is a violation
    always_comb begin
        onehot   = (wr_sel != 8'd0) && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
        wr_valid = wr_en && onehot;
        sel_viol = wr_en && !onehot;
        wr_idx   = 3'd0;
        for (int i = 0; i < 8; i++)
            if (wr_sel[i]) wr_idx = 3'(i);
    end

    // Next read data: zero register wins, then the bypassed write, then stored contents
    always_comb begin
        rd_data_a_d = (ZERO_REG && rd_addr_a == 3'd7) ? '0 :
                      (wr_valid && wr_idx == rd_addr_a) ? wr_data : regs_q[rd_addr_a];
        rd_data_b_d = (ZERO_REG && rd_addr_b == 3'd7) ? '0 :
                      (wr_valid && wr_idx == rd_addr_b) ? wr_data : regs_q[rd_addr_b];
    end

    // Error tracking: a violation on the same edge as a clear restarts the log at one event
    always_comb begin
        sel_err_d   = sel_viol ? 1'b1 : (err_clr ? 1'b0 : sel_err_q);
        err_count_d = sel_viol ? (err_clr ? 8'd1 : (err_count_q == 8'hFF ? 8'hFF : err_count_q + 8'd1)) :
                      (err_clr ? 8'd0 : err_count_q);
    end

    // Register array update; register 7 is never written when it is the hardwired zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (wr_valid && wr_idx == 3'(i) && !(ZERO_REG && i == 7)) regs_q[i] <= wr_data;
        end
    end

    // Read-port and error-log registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data_a_q <= '0;
            rd_data_b_q <= '0;
            sel_err_q   <= 1'b0;
            err_count_q <= 8'd0;
        end else begin
            rd_data_a_q <= rd_data_a_d;
            rd_data_b_q <= rd_data_b_d;
            sel_err_q   <= sel_err_d;
            err_count_q <= err_count_d;
        end
    end

    assign rd_data_a = rd_data_a_q;
    assign rd_data_b = rd_data_b_q;
    assign sel_err   = sel_err_q;
    assign err_count = err_count_q;
endmodule

// File: tb/tb_regfile_bank8.sv
// tb_regfile_bank8: randomized and directed checks of regfile_bank8 against a behavioural model.
module tb_regfile_bank8;
    localparam int WIDTH    = 32;
    localparam bit ZERO_REG = 1'b1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             wr_en = 1'b0;
    logic [7:0]       wr_sel = 8'd0;
    logic [WIDTH-1:0] wr_data = '0;
    logic [2:0]       rd_addr_a = 3'd0;
    logic [2:0]       rd_addr_b = 3'd0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] rd_data_a, rd_data_b;
    logic             sel_err;
    logic [7:0]       err_count;

    int n_vec = 0;
    int n_err = 0;

    logic [WIDTH-1:0] mem [8];
    logic [WIDTH-1:0] ma, mb;
    logic             me;
    int               mc;

    regfile_bank8 #(.WIDTH(WIDTH), .ZERO_REG(ZERO_REG)) dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .err_clr(err_clr),
        .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .sel_err(sel_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        ma = '0;
        mb = '0;
        me = 1'b0;
        mc = 0;
    endtask

    // Advance one clock: model follows the rules with the inputs present at the edge
    task automatic tick();
        @(posedge clk);
        if (!reset_n) model_reset();
        else begin
            if (wr_en && $countones(wr_sel) == 1)
                for (int i = 0; i < 8; i++)
                    if (wr_sel[i] && !(ZERO_REG && i == 7)) mem[i] = wr_data;
            ma = (ZERO_REG && rd_addr_a == 3'd7) ? '0 : mem[rd_addr_a];
            mb = (ZERO_REG && rd_addr_b == 3'd7) ? '0 : mem[rd_addr_b];
            if (wr_en && $countones(wr_sel) != 1) begin
                me = 1'b1;
                mc = err_clr ? 1 : (mc >= 255 ? 255 : mc + 1);
            end else if (err_clr) begin
                me = 1'b0;
                mc = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_data_a, rd_data_b, sel_err, err_count} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got a=%h b=%h err=%b cnt=%0d, want all 0", rd_data_a, rd_data_b, sel_err, err_count);
        end
        tick();
        tick();
        reset_n = 1'b1;
        rd_addr_a = 3'd3;
        rd_addr_b = 3'd5;
        tick();
        n_vec++;
        if ({rd_data_a, rd_data_b, sel_err, err_count} !== '0) begin
            n_err++;
            $display("FAIL reset_read: got a=%h b=%h err=%b cnt=%0d, want all 0", rd_data_a, rd_data_b, sel_err, err_count);
        end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1;
        wr_sel = 8'b0000_0100;
        wr_data = 32'hDEAD_BEEF;
        tick();
        wr_en = 1'b0;
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd0;
        tick();
        n_vec++;
        if (rd_data_a !== 32'hDEAD_BEEF) begin
            n_err++;
            $display("FAIL write_read: got a=%h, want deadbeef", rd_data_a);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 2) continue;
            rd_addr_b = 3'(i);
            tick();
            n_vec++;
            if (rd_data_b !== '0) begin
                n_err++;
                $display("FAIL write_other_reg%0d: got b=%h, want 0", i, rd_data_b);
            end
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1;
        wr_sel = 8'b0010_0000;
        wr_data = 32'h1234_5678;
        rd_addr_a = 3'd5;
        rd_addr_b = 3'd5;
        tick();
        wr_en = 1'b0;
        n_vec++;
        if (rd_data_a !== 32'h1234_5678 || rd_data_b !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL bypass: got a=%h b=%h, want 12345678 on both", rd_data_a, rd_data_b);
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1;
        wr_sel = 8'b1000_0000;
        wr_data = 32'hFFFF_FFFF;
        rd_addr_a = 3'd7;
        tick();
        n_vec++;
        if (rd_data_a !== '0) begin
            n_err++;
            $display("FAIL zero_reg_bypass: got a=%h, want 0", rd_data_a);
        end
        wr_en = 1'b0;
        tick();
        n_vec++;
        if (rd_data_a !== '0 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL zero_reg_read: got a=%h err=%b, want 0 0", rd_data_a, sel_err);
        end
    endtask

    task automatic test_sel_err();
        wr_data = 32'hA5A5_A5A5;
        wr_en = 1'b1;
        wr_sel = 8'b0000_0011;
        tick();
        wr_sel = 8'h00;
        tick();
        wr_en = 1'b0;
        wr_sel = 8'hFF;
        tick();
        n_vec++;
        if (err_count !== 8'd2 || sel_err !== 1'b1) begin
            n_err++;
            $display("FAIL sel_err_count: got cnt=%0d err=%b, want 2 1", err_count, sel_err);
        end
        rd_addr_a = 3'd2;
        rd_addr_b = 3'd5;
        wr_sel = 8'd0;
        tick();
        n_vec++;
        if (rd_data_a !== 32'hDEAD_BEEF || rd_data_b !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL sel_err_nowrite: got a=%h b=%h, want deadbeef 12345678", rd_data_a, rd_data_b);
        end
        for (int i = 0; i < 8; i++) begin
            rd_addr_a = 3'(i);
            tick();
            n_vec++;
            if (rd_data_a !== ma) begin
                n_err++;
                $display("FAIL sel_err_reg%0d: got %h, want %h", i, rd_data_a, ma);
            end
        end
        wr_en = 1'b1;
        wr_sel = 8'hC0;
        err_clr = 1'b1;
        tick();
        n_vec++;
        if (err_count !== 8'd1 || sel_err !== 1'b1) begin
            n_err++;
            $display("FAIL clr_with_viol: got cnt=%0d err=%b, want 1 1", err_count, sel_err);
        end
        wr_en = 1'b0;
        tick();
        err_clr = 1'b0;
        n_vec++;
        if (err_count !== 8'd0 || sel_err !== 1'b0) begin
            n_err++;
            $display("FAIL clr_alone: got cnt=%0d err=%b, want 0 0", err_count, sel_err);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            wr_en = ($urandom_range(0, 3) != 0);
            wr_sel = (r < 8) ? (8'd1 << r) : 8'($urandom);
            wr_data = $urandom;
            rd_addr_a = 3'($urandom_range(0, 7));
            rd_addr_b = ($urandom_range(0, 2) == 0) ? 3'(r) : 3'($urandom_range(0, 7));
            err_clr = ($urandom_range(0, 9) == 0);
            tick();
            n_vec++;
            if ({rd_data_a, rd_data_b, sel_err, err_count} !== {ma, mb, me, 8'(mc)}) begin
                n_err++;
                $display("FAIL random[%0d]: got a=%h b=%h err=%b cnt=%0d, want a=%h b=%h err=%b cnt=%0d",
                         n, rd_data_a, rd_data_b, sel_err, err_count, ma, mb, me, mc);
            end
        end
        wr_en = 1'b0;
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    task automatic test_saturation();
        wr_en = 1'b1;
        wr_sel = 8'h03;
        for (int n = 0; n < 260; n++) tick();
        wr_en = 1'b0;
        n_vec++;
        if (err_count !== 8'd255 || sel_err !== 1'b1) begin
            n_err++;
            $display("FAIL saturate: got cnt=%0d err=%b, want 255 1", err_count, sel_err);
        end
        rd_addr_a = 3'($urandom_range(0, 6));
        rd_addr_b = 3'($urandom_range(0, 6));
        tick();
        n_vec++;
        if ({rd_data_a, rd_data_b} !== {ma, mb}) begin
            n_err++;
            $display("FAIL pre_reset_read: got a=%h b=%h, want a=%h b=%h", rd_data_a, rd_data_b, ma, mb);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({rd_data_a, rd_data_b, sel_err, err_count} !== '0) begin
            n_err++;
            $display("FAIL midcycle_reset: got a=%h b=%h err=%b cnt=%0d, want all 0", rd_data_a, rd_data_b, sel_err, err_count);
        end
        model_reset();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            rd_addr_a = 3'(i);
            tick();
            n_vec++;
            if (rd_data_a !== '0) begin
                n_err++;
                $display("FAIL post_reset_reg%0d: got %h, want 0", i, rd_data_a);
            end
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_sel_err();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
